// File: rtl/aoi_rr_arbiter.sv
// Round-robin arbiter for up to eight requesters: registered one-hot grant held until release, then a one-cycle gap.
// Define AOI_RR_ARBITER_TIMEOUT_EN to force a release after MAX_HOLD cycles and pulse TIMEOUT on that release.
module aoi_rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic                    CK,
    input  logic                    RN,
    input  logic [NREQ-1:0]         REQ,
    output logic [NREQ-1:0]         GNT,
    output logic                    GNT_VALID,
    output logic [$clog2(NREQ)-1:0] GNT_ID,
    output logic                    TIMEOUT
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("aoi_rr_arbiter: NREQ must be in 2..8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("aoi_rr_arbiter: MAX_HOLD must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  owner, owner_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic            timeout_nxt;
    logic            arb_hit;
    logic [IDW-1:0]  arb_idx;
    logic [NREQ-1:0] gnt_nxt;

    // Scan REQ from ptr upward, wrapping at NREQ (not at a power of two).
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            int             pos;
            logic [IDW-1:0] pos_idx;
            pos = int'(ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            pos_idx = IDW'(pos);
            if (!arb_hit && REQ[pos_idx]) begin
                arb_hit = 1'b1;
                arb_idx = pos_idx;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE, GAP: begin
                state_nxt = IDLE;
                if (arb_hit) begin
                    state_nxt = BUSY;
                    owner_nxt = arb_idx;
                    ptr_nxt   = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (!REQ[owner]) begin
                    state_nxt = GAP;
`ifdef AOI_RR_ARBITER_TIMEOUT_EN
                end else if (cnt == 8'(MAX_HOLD - 1)) begin
                    state_nxt   = GAP;
                    timeout_nxt = 1'b1;
`endif
                end else if (cnt != 8'hFF) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt = '0;
        if (state_nxt == BUSY) gnt_nxt[owner_nxt] = 1'b1;
    end

    // Outputs come straight from flops so nothing combinational reaches them from REQ.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            cnt       <= '0;
            GNT       <= '0;
            GNT_VALID <= 1'b0;
            GNT_ID    <= '0;
            TIMEOUT   <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            GNT       <= gnt_nxt;
            GNT_VALID <= (state_nxt == BUSY);
            GNT_ID    <= (state_nxt == BUSY) ? owner_nxt : '0;
            TIMEOUT   <= timeout_nxt;
        end
    end

endmodule

// File: doc/aoi_rr_arbiter.md
# aoi_rr_arbiter

Round-robin arbiter that shares one downstream resource, such as a shared pad driver, a scan-mux select or a bus built from the library's AOI/OAI cells, among up to eight requesters. It runs from one clock and issues registered, one-hot grants. Each grant is held until its requester releases the resource, and one idle turnaround cycle separates consecutive grants. The block sits between the requesting cores and the shared resource's select logic.

## Interface
- NREQ, 4: number of requesters, legal range 2..8.
- MAX_HOLD, 15: maximum cycles a grant is held before forced release. Legal range 1..255. Used only when the timeout feature is compiled in.
- CK input 1: clock; all state changes on the rising edge.
- RN input 1: reset; asynchronous assert, active-low; release is synchronous to the next CK rising edge.
- REQ input NREQ: level request; bit i held high while requester i wants or holds the resource.
- GNT output NREQ: registered one-hot grant; all-zero when nobody holds the resource.
- GNT_VALID output 1: registered; equals the OR of GNT.
- GNT_ID output ceil(log2(NREQ)): registered binary index of the granted requester; 0 when GNT_VALID is 0.
- TIMEOUT output 1: registered one-cycle pulse on a forced release; constant 0 when the feature is compiled out.

## Operation
- States are IDLE, BUSY and GAP. The state, the owner index, the priority pointer PTR (ID width) and the hold counter (8 bits) are all registered.
- **Reset (RN=0):** immediately drives GNT=0, GNT_VALID=0, GNT_ID=0 and TIMEOUT=0. State goes to IDLE, PTR to 0 and the counter to 0. This applies in any state, including mid-grant.
- **Arbitration function:** scans REQ starting at index PTR and wrapping modulo NREQ. The first set bit wins. On every grant, PTR is set to (winner+1) mod NREQ.
- **IDLE:**
  - If REQ≠0 at the edge, arbitrate, load the owner, go to BUSY and clear the counter.
  - Otherwise stay in IDLE.
- **BUSY:**
  - If REQ[owner]=1, stay in BUSY and increment the counter, saturating at 255.
  - If REQ[owner]=0, go to GAP.
  - REQ bits of non-owners are ignored in BUSY.
- **GAP:**
  - Lasts exactly one cycle, with GNT all-zero.
  - At the edge leaving GAP: arbitrate and go to BUSY if REQ≠0; otherwise go to IDLE.
- **Outputs:** GNT is one-hot of the owner while in BUSY and zero otherwise. GNT_ID and GNT_VALID track GNT. No combinational path exists from REQ to any output.
- **Fairness:** with every REQ bit held high, grants rotate 0,1,2,…,NREQ-1,0,…
- **Single requester:** the same requester is re-granted after each GAP.
- **Same-edge events:** an owner release sampled at the same edge as new requests still passes through GAP. New requests are only considered at the GAP-exit edge.
- **REQ of an unused index:** bits at or above NREQ do not exist; the PTR wrap uses NREQ, not a power of two.

## Timing
- REQ rising in IDLE at edge t gives GNT high from just after t, which is 1-cycle latency.
- Owner REQ sampled low at edge t gives GNT low after t, and the next grant after t+1. The minimum gap is one cycle.
- Hold cycles counted: the counter equals the number of BUSY cycles completed with REQ[owner]=1.
- Reset assertion acts asynchronously and clears outputs within the RN-to-Q delay of the library DFFR cells. The first arbitration happens at the first edge after RN rises.

## Configuration
- **Macro:** AOI_RR_ARBITER_TIMEOUT_EN.
- **Defined:**
  - In BUSY, if the counter equals MAX_HOLD-1 and REQ[owner]=1 at the edge, force a transition to GAP and assert TIMEOUT for exactly the following cycle. A grant therefore never exceeds MAX_HOLD cycles.
  - PTR has already moved past the owner, so other requesters win the next arbitration.
  - If the timed-out requester is the only one requesting, it is re-granted after GAP.
- **Undefined:** the counter comparison is removed, grants are held indefinitely, and TIMEOUT is tied to 0. The port list is identical in both builds.

## Test plan
- **Reset values:** RN=0 with REQ=4'b1111 → GNT=0, GNT_VALID=0, GNT_ID=0, TIMEOUT=0. After RN rises, the first edge gives GNT=4'b0001.
- **Rotation:** REQ=4'b1111 held, each owner drops its REQ for one cycle after 2 cycles of grant → GNT sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- **Hold and ignore:** REQ=4'b0100, then REQ[0] rises mid-grant → GNT stays 0100 until REQ[2] falls. GNT is 0000 for one cycle, then 0001 with GNT_ID=0.
- **Mid-grant reset:** with GNT=0010, pulse RN low between edges → GNT drops to 0 without a clock edge. Afterwards REQ=4'b0110 gives GNT=0010, since PTR was reset to 0.
- **Timeout (macro defined, MAX_HOLD=3):** REQ=4'b0011 held → GNT=0001 for exactly 3 cycles, then TIMEOUT=1 with GNT=0000, then GNT=0010.
- **Macro undefined:** same stimulus as the timeout case → GNT=0001 holds for 100 cycles and TIMEOUT stays 0.
